// File: rtl/decoder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decoder_pkg : shared FSM state type and one-hot helper for decoder_scan
// Rev 1.0
// ---------------------------------------------------------------------------
package decoder_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam int MAX_SEL_W = 6;

    // Full-width result; callers keep the low 2**SEL_W bits.
    function automatic logic [(2**MAX_SEL_W)-1:0] onehot(input logic [MAX_SEL_W-1:0] i);
        onehot = {{((2**MAX_SEL_W)-1){1'b0}}, 1'b1} << i;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_onehot.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decoder_onehot : combinational SEL_W -> 2**SEL_W one-hot decoder with enable
// Rev 1.0
// ---------------------------------------------------------------------------
module decoder_onehot
    import decoder_pkg::*;
#(
    parameter int SEL_W = 4,
    parameter int OUT_W = 2**SEL_W
) (
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] y
);

    logic [(2**MAX_SEL_W)-1:0] full;

    always_comb begin
        full = onehot(MAX_SEL_W'(sel));
        y    = en ? full[OUT_W-1:0] : '0;
    end

endmodule
`default_nettype wire

// File: rtl/decoder_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decoder_scan : registered one-hot decoder with direct-load and auto-scan modes
// Rev 1.0
// ---------------------------------------------------------------------------
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W = 4,
    parameter int HOLD  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  load,
    input  logic [SEL_W-1:0]      sel,
    output logic [(2**SEL_W)-1:0] dout,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);

    localparam int OUT_W = 2**SEL_W;
    localparam int CNT_W = ($clog2(HOLD + 1) < 1) ? 1 : $clog2(HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   hcnt_q, hcnt_d;
    logic [OUT_W-1:0]   dout_q, dout_d;
    logic               wrap_q, wrap_d;

    always_comb begin
        state_d = ST_OFF;
        idx_d   = idx_q;
        hcnt_d  = hcnt_q;
        wrap_d  = 1'b0;

        if (en) begin
            state_d = mode ? ST_SCAN : ST_DIRECT;
        end

        case (state_d)
            ST_OFF: begin
            end
            ST_DIRECT: begin
                hcnt_d = '0;
                if (load) begin
                    idx_d = sel;
                end
            end
            ST_SCAN: begin
                if (load) begin
                    idx_d  = sel;
                    hcnt_d = '0;
                end else if (state_q != ST_SCAN) begin
                    // Entry cycle: present the retained index, start a fresh hold
                    hcnt_d = '0;
                end else if (hcnt_q == HOLD_LAST) begin
                    hcnt_d = '0;
                    idx_d  = idx_q + 1'b1;
                    wrap_d = (idx_q == {SEL_W{1'b1}});
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    decoder_onehot #(
        .SEL_W (SEL_W),
        .OUT_W (OUT_W)
    ) u_onehot (
        .en  (state_d != ST_OFF),
        .sel (idx_d),
        .y   (dout_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            idx_q   <= '0;
            hcnt_q  <= '0;
            dout_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hcnt_q  <= hcnt_d;
            dout_q  <= dout_d;
            wrap_q  <= wrap_d;
        end
    end

    assign dout = dout_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_decoder_scan : directed self-checking bench, HOLD=1 and HOLD=3 instances
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_decoder_scan;

    logic        clk = 1'b0;
    logic        rst, en, mode, load;
    logic [3:0]  sel;
    logic [15:0] dout1, dout3;
    logic [3:0]  idx1, idx3;
    logic        wrap1, wrap3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decoder_scan #(.SEL_W(4), .HOLD(1)) u_h1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel(sel),
        .dout(dout1), .idx(idx1), .wrap(wrap1)
    );

    decoder_scan #(.SEL_W(4), .HOLD(3)) u_h3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel(sel),
        .dout(dout3), .idx(idx3), .wrap(wrap3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        check("onehot_h1", {31'd0, ($countones(dout1) <= 1)}, 32'd1);
        check("onehot_h3", {31'd0, ($countones(dout3) <= 1)}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; sel = 4'd0;
        step;
        step;
        check("rst_dout_h1", 32'(dout1), 32'h0);
        check("rst_idx_h1",  32'(idx1),  32'h0);
        check("rst_wrap_h1", 32'(wrap1), 32'h0);
        check("rst_dout_h3", 32'(dout3), 32'h0);

        // Direct mode out of reset starts at index 0
        rst = 1'b0; en = 1'b1; mode = 1'b0;
        step;
        check("direct_start_dout", 32'(dout1), 32'h0001);
        check("direct_start_idx",  32'(idx1),  32'h0);

        // Direct load of 9, then hold while sel changes
        load = 1'b1; sel = 4'd9;
        step;
        load = 1'b0; sel = 4'd3;
        check("direct_load_dout", 32'(dout1), 32'h0200);
        check("direct_load_idx",  32'(idx1),  32'd9);
        for (int i = 0; i < 3; i++) begin
            step;
            check("direct_hold_dout", 32'(dout1), 32'h0200);
            check("direct_hold_idx",  32'(idx1),  32'd9);
        end

        // Scan wrap with HOLD=1 from index 14
        load = 1'b1; sel = 4'd14;
        step;
        load = 1'b0; mode = 1'b1;
        check("wrap_pre_dout", 32'(dout1), 32'h4000);
        step;
        check("wrap_c0_dout", 32'(dout1), 32'h4000);
        check("wrap_c0_wrap", 32'(wrap1), 32'h0);
        step;
        check("wrap_c1_dout", 32'(dout1), 32'h8000);
        check("wrap_c1_wrap", 32'(wrap1), 32'h0);
        step;
        check("wrap_c2_dout", 32'(dout1), 32'h0001);
        check("wrap_c2_wrap", 32'(wrap1), 32'h1);
        step;
        check("wrap_c3_dout", 32'(dout1), 32'h0002);
        check("wrap_c3_wrap", 32'(wrap1), 32'h0);

        // Full scan with HOLD=3: 48 cycles for 0..15, then wrap
        rst = 1'b1;
        step;
        rst = 1'b0; en = 1'b1; mode = 1'b1; load = 1'b0;
        for (int c = 0; c < 48; c++) begin
            step;
            check("hold_idx",  32'(idx3),  32'(c / 3));
            check("hold_dout", 32'(dout3), 32'd1 << (c / 3));
            check("hold_wrap", 32'(wrap3), 32'h0);
        end
        step;
        check("hold_end_idx",  32'(idx3),  32'h0);
        check("hold_end_dout", 32'(dout3), 32'h0001);
        check("hold_end_wrap", 32'(wrap3), 32'h1);

        // Load of 5 on the second cycle of index 2
        rst = 1'b1;
        step;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step;
            check("lscan_idx", 32'(idx3), 32'(c / 3));
        end
        load = 1'b1; sel = 4'd5;
        step;
        load = 1'b0;
        check("lscan_load_idx",  32'(idx3),  32'd5);
        check("lscan_load_dout", 32'(dout3), 32'h0020);
        check("lscan_load_wrap", 32'(wrap3), 32'h0);
        for (int c = 1; c < 3; c++) begin
            step;
            check("lscan_hold_idx",  32'(idx3),  32'd5);
            check("lscan_hold_wrap", 32'(wrap3), 32'h0);
        end
        step;
        check("lscan_next_idx", 32'(idx3), 32'd6);
        step;
        step;
        step;
        check("gate_pre_idx", 32'(idx3), 32'd7);

        // Enable gating at index 7
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step;
            check("gate_off_dout", 32'(dout3), 32'h0);
            check("gate_off_idx",  32'(idx3),  32'd7);
            check("gate_off_wrap", 32'(wrap3), 32'h0);
        end
        en = 1'b1;
        step;
        check("gate_resume_dout", 32'(dout3), 32'h0080);
        check("gate_resume_idx",  32'(idx3),  32'd7);
        step;
        step;
        check("gate_hold_idx", 32'(idx3), 32'd7);
        step;
        check("gate_adv_idx",  32'(idx3),  32'd8);
        check("gate_adv_dout", 32'(dout3), 32'h0100);

        // Reset at index 11 overrides a simultaneous load
        load = 1'b1; sel = 4'd11;
        step;
        check("mrst_pre_idx", 32'(idx3), 32'd11);
        rst = 1'b1; load = 1'b1; sel = 4'd3;
        step;
        check("mrst_idx",  32'(idx3),  32'h0);
        check("mrst_dout", 32'(dout3), 32'h0);
        check("mrst_wrap", 32'(wrap3), 32'h0);
        check("mrst_idx_h1", 32'(idx1), 32'h0);
        rst = 1'b0; load = 1'b0; mode = 1'b0;
        step;
        check("mrst_after_idx",  32'(idx3),  32'h0);
        check("mrst_after_dout", 32'(dout3), 32'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
